// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores to a variable-latency data memory,
// stalls upstream while an access is outstanding, flags accesses that exceed
// the wait bound, and registers results into the MEM/WB register.
module mem_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWr_EX,
  input  logic              MemWr_EX,
  input  logic              MemRd_EX,
  input  logic [1:0]        WBdata_EX,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] npc3,
  input  logic [REG_W-1:0]  rd3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              RegWr_MEM,
  output logic [1:0]        WBdata_MEM,
  output logic [DATA_W-1:0] ALUout4,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] npc4,
  output logic [REG_W-1:0]  rd4,
  output logic              mem_err
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic access;
  logic is_read;
  logic req_int;
  logic timeout;
  logic capture;
  logic set_err;

  // A request with both read and write set behaves as a write.
  assign access  = MemRd_EX | MemWr_EX;
  assign is_read = MemRd_EX & ~MemWr_EX;

  assign req_int = access & ((state_reg == IDLE) | (state_reg == WAIT));
  assign timeout = (state_reg == WAIT) & (count_reg == CNT_MAX);

  // Request and stall are suppressed while reset is held so upstream is
  // never frozen by an access the reset is about to abandon.
  assign dmem_req   = req_int & rst;
  assign stall      = req_int & ~dmem_ack & ~timeout & rst;
  assign dmem_we    = MemWr_EX;
  assign dmem_addr  = ALUout;
  assign dmem_wdata = D;

  // Next-state and wait-count logic; decides between capture and bubble.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!access || dmem_ack) begin
          capture = 1'b1;
        end else begin
          state_next = WAIT;
          count_next = CNT_ONE;
        end
      end
      WAIT: begin
        if (!access || dmem_ack) begin
          capture    = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else if (timeout) begin
          // Retire the failed access without a register write.
          set_err    = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // FSM state, sticky error flag and MEM/WB register update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mem_err    <= 1'b0;
      RegWr_MEM  <= 1'b0;
      WBdata_MEM <= 2'b00;
      ALUout4    <= '0;
      MDR        <= '0;
      npc4       <= '0;
      rd4        <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (set_err) begin
        mem_err <= 1'b1;
      end
      if (capture) begin
        RegWr_MEM  <= RegWr_EX;
        WBdata_MEM <= WBdata_EX;
        ALUout4    <= ALUout;
        npc4       <= npc3;
        rd4        <= rd3;
        if (is_read && dmem_ack) begin
          MDR <= dmem_rdata;
        end
      end else begin
        // Bubble: only the write enable drops, the data fields hold.
        RegWr_MEM <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// instructions, with a transaction-level model feeding a scoreboard queue.
module tb_mem_stage;

  localparam int MAX_WAIT = 15;
  localparam int NEVER    = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWr_EX = 1'b0, MemWr_EX = 1'b0, MemRd_EX = 1'b0;
  logic [1:0]  WBdata_EX = 2'b00;
  logic [31:0] ALUout = '0, D = '0, npc3 = '0;
  logic [3:0]  rd3 = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall;
  logic        RegWr_MEM;
  logic [1:0]  WBdata_MEM;
  logic [31:0] ALUout4, MDR, npc4;
  logic [3:0]  rd4;
  logic        mem_err;

  mem_stage #(.DATA_W(32), .REG_W(4), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .RegWr_EX(RegWr_EX), .MemWr_EX(MemWr_EX), .MemRd_EX(MemRd_EX),
    .WBdata_EX(WBdata_EX), .ALUout(ALUout), .D(D), .npc3(npc3), .rd3(rd3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .RegWr_MEM(RegWr_MEM), .WBdata_MEM(WBdata_MEM),
    .ALUout4(ALUout4), .MDR(MDR), .npc4(npc4), .rd4(rd4), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stalls;
    logic        regwr;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] mdr;
    logic [31:0] npc;
    logic [3:0]  rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Architectural MEM/WB contents as the model sees them.
  logic [1:0]  m_wb  = 2'b00;
  logic [31:0] m_alu = '0, m_mdr = '0, m_npc = '0;
  logic [3:0]  m_rd  = '0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_wb = 2'b00; m_alu = '0; m_mdr = '0; m_npc = '0; m_rd = '0; m_err = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_regwr", {31'd0, RegWr_MEM}, 32'd0);
    check("rst_wbdata", {30'd0, WBdata_MEM}, 32'd0);
    check("rst_alu4", ALUout4, 32'd0);
    check("rst_mdr", MDR, 32'd0);
    check("rst_npc4", npc4, 32'd0);
    check("rst_rd4", {28'd0, rd4}, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
  endtask

  // Present one instruction; lat = cycle index (0 = same cycle) of the ack.
  task automatic issue(input logic rw, input logic mr, input logic mw,
                       input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] d, input logic [31:0] npc,
                       input logic [3:0] rd, input int lat,
                       input logic [31:0] data, input logic spur);
    exp_t e;
    logic acc;
    logic st;
    acc = mr | mw;
    if (!acc || lat <= MAX_WAIT) begin
      e.stalls = acc ? lat : 0;
      e.regwr  = rw;
      m_wb = wb; m_alu = alu; m_npc = npc; m_rd = rd;
      if (mr && !mw) m_mdr = data;
    end else begin
      e.stalls = MAX_WAIT;
      e.regwr  = 1'b0;
      m_err    = 1'b1;
    end
    e.wb = m_wb; e.alu = m_alu; e.mdr = m_mdr; e.npc = m_npc; e.rd = m_rd; e.err = m_err;
    exp_q.push_back(e);

    RegWr_EX = rw; MemRd_EX = mr; MemWr_EX = mw; WBdata_EX = wb;
    ALUout = alu; D = d; npc3 = npc; rd3 = rd;
    for (int k = 0; k <= 40; k++) begin
      if (k == 40) begin
        checks++; errors++;
        $display("FAIL stall_bound actual=stall held 40 cycles required=release");
        break;
      end
      dmem_ack   = acc ? (k == lat) : spur;
      dmem_rdata = (acc && k == lat) ? data : $urandom;
      @(negedge clk);
      check("dmem_req", {31'd0, dmem_req}, {31'd0, acc});
      check("dmem_we", {31'd0, dmem_we}, {31'd0, mw});
      check("dmem_addr", dmem_addr, alu);
      check("dmem_wdata", dmem_wdata, d);
      st = stall;
      @(posedge clk); #1;
      if (!st) break;
    end
    dmem_ack = 1'b0;
  endtask

  // Monitor: a non-stalled, out-of-reset cycle retires an instruction into MEM/WB.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
      end else if (stall) begin
        stall_cnt++;
        if (stall_cnt >= 2) check("bubble_regwr", {31'd0, RegWr_MEM}, 32'd0);
      end else begin
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_retire actual=retire required=none");
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", stall_cnt, e.stalls);
          check("RegWr_MEM", {31'd0, RegWr_MEM}, {31'd0, e.regwr});
          check("WBdata_MEM", {30'd0, WBdata_MEM}, {30'd0, e.wb});
          check("ALUout4", ALUout4, e.alu);
          check("MDR", MDR, e.mdr);
          check("npc4", npc4, e.npc);
          check("rd4", {28'd0, rd4}, {28'd0, e.rd});
          check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        end
        stall_cnt = 0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    int op, lr, lat;
    // Reset with a load pending: request and stall must stay low.
    MemRd_EX = 1'b1; ALUout = 32'h80;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b1;

    issue(1, 0, 0, 2'b01, 32'h12, 32'h0, 32'h101, 4'd5, 0, 32'h0, 0);
    issue(1, 1, 0, 2'b10, 32'h40, 32'h0, 32'h102, 4'd6, 0, 32'hDEADBEEF, 0);
    issue(0, 0, 1, 2'b00, 32'h44, 32'hCAFE0001, 32'h103, 4'd7, 3, 32'h0, 0);
    issue(1, 1, 1, 2'b11, 32'h48, 32'h5555AAAA, 32'h104, 4'd8, 0, 32'h01234567, 0);
    issue(1, 0, 0, 2'b01, 32'h99, 32'h0, 32'h105, 4'd9, 0, 32'h0, 1);
    issue(1, 1, 0, 2'b10, 32'h4C, 32'h0, 32'h106, 4'd10, MAX_WAIT, 32'h13572468, 0);
    issue(1, 1, 0, 2'b10, 32'h50, 32'h0, 32'h107, 4'd11, NEVER, 32'h0, 0);
    issue(1, 0, 0, 2'b01, 32'h77, 32'h0, 32'h108, 4'd12, 0, 32'h0, 0);

    // Reset while waiting on a load: abandoned with no MEM/WB write.
    RegWr_EX = 1; MemRd_EX = 1; MemWr_EX = 0; ALUout = 32'h60; rd3 = 4'd13;
    dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state();
    model_reset();
    rst = 1'b1;
    issue(1, 1, 0, 2'b10, 32'h64, 32'h0, 32'h109, 4'd14, 1, 32'h0BADF00D, 0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      lr = $urandom_range(0, 19);
      if (lr < 8)       lat = 0;
      else if (lr < 17) lat = $urandom_range(1, 6);
      else if (lr == 17) lat = MAX_WAIT;
      else if (lr == 18) lat = MAX_WAIT - 1;
      else              lat = NEVER;
      issue($urandom_range(0, 1), (op >= 4 && op <= 6) || op == 9, op >= 7,
            2'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
            lat, $urandom, 1'($urandom));
    end

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
